i2c_eeprom_top: RTL and testbench
=================================

// Module: i2c_eeprom_top
// PURPOSE
// - Single-master I2C controller for byte write/read to a 7-bit-addressed EEPROM-style slave.
// - Host pulses newd with addr/wr/wdata; block runs one full I2C transaction and pulses done.
// - Sits between a host register interface and the board-level SCL/SDA pins.
// PARAMETERS
// - QCNT  default 10  clk cycles per quarter SCL period (SCL period = 4*QCNT = 400 ns at 100 MHz)
// PORTS
// - clk    in     1  system clock, all logic on rising edge
// - rst    in     1  asynchronous, active-high reset
// - newd   in     1  start-transaction strobe, sampled in IDLE only
// - ack    in     1  host-side acknowledge override; high during an ACK slot counts as ACK
// - wr     in     1  1 = write (R/W bit 0), 0 = read (R/W bit 1); latched at start
// - scl    out    1  I2C clock, push-pull, idle high
// - sda    inout  1  I2C data; driven with internal sda_out when sda_en=1, else 1'bz
// - wdata  in     8  write data byte, latched at start
// - addr   in     7  slave address, latched at start
// - rdata  out    8  last byte read, updated only at end of a read
// - done   out    1  one-clk pulse when a transaction finishes (ACK or NACK)
// - Internal reg sda_en (1 = master drives SDA) is part of the contract; benches probe it.
// BEHAVIOUR
// - Reset (async): state IDLE, scl=1, sda_en=1, sda_out=1, done=0, rdata=8'h00, counters 0.
// - Reset mid-transfer aborts immediately to the reset state; no STOP generated.
// - Bit timing: every bit = 4 quarters of QCNT clks:
//   q0 SCL low, SDA updated; q1 SCL high; q2 SCL high, SDA sampled at q2 entry; q3 SCL low.
// - States: IDLE -> START -> ADDR(8 bits) -> ADDR_ACK -> {WDATA -> WDATA_ACK | RDATA -> MNACK} -> STOP -> DONE -> IDLE.
// - IDLE: scl=1, sda_en=1, sda_out=1. newd=1 latches addr, wr, wdata; goes to START.
//   newd outside IDLE is ignored.
// - START: SDA falls while SCL high (q0-q1 SDA=1, q2 SDA=0, q3 SCL low).
// - ADDR: shifts {addr[6:0], ~wr}, MSB first, sda_en=1.
// - ADDR_ACK: sda_en=0 for one bit. ACK if sda sampled 0 at q2 OR ack=1 at any clk of the slot.
//   ACK: wr=1 -> WDATA, wr=0 -> RDATA. NACK -> STOP (no data phase).
// - WDATA: wdata MSB first, sda_en=1. WDATA_ACK: like ADDR_ACK, then STOP either way.
// - RDATA: sda_en=0 for 8 bits. SDA sampled MSB first into a shift register.
//   MNACK: sda_en=1, SDA=1 for one bit. rdata loaded from the shift register at MNACK entry.
// - STOP: SDA=0 with SCL low, SCL high, then SDA rises while SCL high. Ends with scl=1, sda=1.
// - DONE: done=1 for exactly one clk, then IDLE. newd in that same clk is ignored.
// - A write never alters rdata. A NACK never alters rdata.
// - Transaction length, ACK case: write 1+9+9+1 bits, read 1+9+9+1 bits (each 4*QCNT clks) + 1 clk.
// TESTING
// - Reset: rst=1 -> scl=1, sda_en=1, done=0, rdata=00; rst released -> stays IDLE, no SCL toggle.
// - Write addr=50 wdata=A5, slave ACKs by pulling SDA low -> bits 1010000_0, 10100101 on SDA; STOP; done pulses once.
// - Read addr=50, slave ACKs and returns 3C (00111100) -> address byte 10100001, sda_en=0 in data bits,
//   master NACK, STOP, rdata=3C at done.
// - Write with SDA held high and ack=0 through ADDR_ACK -> NACK, STOP right after address, done, rdata unchanged.
// - Write with SDA high but ack pulsed high inside both ACK slots -> treated as ACK, full write completes.
// - Assert rst halfway through the data byte -> immediate IDLE outputs. A later newd starts a clean START.

Source files
------------

// File: rtl/i2c_eeprom_top.sv
// Single-master I2C byte write/read controller for a 7-bit-addressed EEPROM-style slave.
// One host strobe runs START, address, one data byte with ACK handling, STOP, then pulses done.
module i2c_eeprom_top #(
  parameter int unsigned QCNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       ack,
  input  logic       wr,
  output logic       scl,
  inout  wire        sda,
  input  logic [7:0] wdata,
  input  logic [6:0] addr,
  output logic [7:0] rdata,
  output logic       done
);

  localparam int unsigned CW = (QCNT > 1) ? $clog2(QCNT) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MNACK, STOP, DONE
  } state_t;

  state_t state, next;

  logic [CW-1:0] cnt;
  logic [1:0]    ph;
  logic [2:0]    bitn;
  logic          tick, end_bit;

  logic       sda_en, sda_out;
  logic [6:0] addr_l;
  logic       wr_l;
  logic [7:0] wdata_l, shreg, abyte;
  logic       sda_smp, ack_seen, ack_ok, data_scl;
  logic       scl_d, sda_en_d, sda_out_d, done_d;

  assign tick     = (cnt == CW'(QCNT - 1));
  assign end_bit  = tick && (ph == 2'd3);
  assign abyte    = {addr_l, ~wr_l};
  assign ack_ok   = ack_seen | ack | ~sda_smp;
  assign data_scl = (ph == 2'd1) || (ph == 2'd2);
  assign sda      = sda_en ? sda_out : 1'bz;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic; every non-idle state advances only on a bit boundary
  always_comb begin
    next = state;
    case (state)
      IDLE:      if (newd) next = START;
      START:     if (end_bit) next = ADDR;
      ADDR:      if (end_bit && bitn == 3'd7) next = ADDR_ACK;
      ADDR_ACK:  if (end_bit) next = !ack_ok ? STOP : (wr_l ? WDATA : RDATA);
      WDATA:     if (end_bit && bitn == 3'd7) next = WDATA_ACK;
      WDATA_ACK: if (end_bit) next = STOP;
      RDATA:     if (end_bit && bitn == 3'd7) next = MNACK;
      MNACK:     if (end_bit) next = STOP;
      STOP:      if (end_bit) next = DONE;
      DONE:      next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // Per-state pin values by quarter; registered below
  always_comb begin
    scl_d     = 1'b1;
    sda_en_d  = 1'b1;
    sda_out_d = 1'b1;
    done_d    = 1'b0;
    case (state)
      START: begin
        scl_d     = (ph != 2'd3);
        sda_out_d = (ph < 2'd2);
      end
      ADDR: begin
        scl_d     = data_scl;
        sda_out_d = abyte[3'd7 - bitn];
      end
      WDATA: begin
        scl_d     = data_scl;
        sda_out_d = wdata_l[3'd7 - bitn];
      end
      ADDR_ACK, WDATA_ACK, RDATA: begin
        scl_d    = data_scl;
        sda_en_d = 1'b0;
      end
      MNACK: scl_d = data_scl;
      STOP: begin
        scl_d     = (ph != 2'd0);
        sda_out_d = ph[1];
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl     <= 1'b1;
      sda_en  <= 1'b1;
      sda_out <= 1'b1;
      done    <= 1'b0;
    end else begin
      scl     <= scl_d;
      sda_en  <= sda_en_d;
      sda_out <= sda_out_d;
      done    <= done_d;
    end
  end

  // Quarter/bit timing counters, held at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ph   <= 2'd0;
      bitn <= 3'd0;
    end else if (state == IDLE || state == DONE) begin
      cnt  <= '0;
      ph   <= 2'd0;
      bitn <= 3'd0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick)    ph   <= ph + 2'd1;
      if (end_bit) bitn <= (next != state) ? 3'd0 : bitn + 3'd1;
    end
  end

  // Latched request, SDA sampling at q2 entry, ACK capture and read shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_l   <= 7'd0;
      wr_l     <= 1'b0;
      wdata_l  <= 8'd0;
      shreg    <= 8'd0;
      sda_smp  <= 1'b1;
      ack_seen <= 1'b0;
      rdata    <= 8'd0;
    end else begin
      if (state == IDLE && newd) begin
        addr_l  <= addr;
        wr_l    <= wr;
        wdata_l <= wdata;
      end
      if (ph == 2'd1 && tick) begin
        sda_smp <= sda;
        if (state == RDATA) shreg <= {shreg[6:0], sda};
      end
      if (end_bit)  ack_seen <= 1'b0;
      else if (ack) ack_seen <= 1'b1;
      if (state == RDATA && next == MNACK) rdata <= shreg;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_top.sv
// Bench for i2c_eeprom_top: behavioural slave on the bus plus a bit-level model of
// each expected transaction (directed and $urandom cases).
module tb_i2c_eeprom_top;
  localparam int unsigned QCNT   = 10;
  localparam int unsigned BITCLK = 4 * QCNT;

  logic       clk = 1'b0;
  logic       rst, newd, wr;
  logic       ack = 1'b0;
  logic [7:0] wdata, rdata;
  logic [6:0] addr;
  logic       scl, done;
  wire        sda;

  int checks = 0;
  int errors = 0;

  i2c_eeprom_top #(.QCNT(QCNT)) dut (
    .clk(clk), .rst(rst), .newd(newd), .ack(ack), .wr(wr), .scl(scl), .sda(sda),
    .wdata(wdata), .addr(addr), .rdata(rdata), .done(done)
  );

  always #5 clk = ~clk;

  // Slave side: pulls SDA to slave_bit whenever the master releases it (pull-up when 1)
  logic slave_bit = 1'b1;
  assign sda = dut.sda_en ? 1'bz : slave_bit;

  // Slave configuration for the current transaction
  int         rise_base = 0;
  logic       tr_wr = 1'b0;
  logic [7:0] tr_rdata = 8'h00;
  logic       a_ackbit = 1'b0, d_ackbit = 1'b0, p_addr = 1'b0, p_data = 1'b0;

  // Bus monitor
  int   rises = 0, starts = 0, stops = 0, dones = 0;
  logic mon_bits[$];
  logic mon_en[$];

  always @(posedge scl) begin
    mon_bits.push_back(sda);
    mon_en.push_back(dut.sda_en);
    rises++;
  end
  always @(negedge sda) if (scl === 1'b1) starts++;
  always @(posedge sda) if (scl === 1'b1) stops++;
  always @(posedge clk) if (done === 1'b1) dones++;

  // Slave behaviour: set the next bit while SCL is low; optionally pulse the host ack pin
  always @(negedge scl) begin : slave
    int idx;
    idx = rises - rise_base;
    if (idx == 8) begin
      slave_bit = a_ackbit;
      if (p_addr) begin
        repeat (QCNT + 5) @(posedge clk);
        ack = 1'b1;
        repeat (2) @(posedge clk);
        ack = 1'b0;
      end
    end else if (tr_wr && idx == 17) begin
      slave_bit = d_ackbit;
      if (p_data) begin
        repeat (QCNT + 5) @(posedge clk);
        ack = 1'b1;
        repeat (2) @(posedge clk);
        ack = 1'b0;
      end
    end else if (!tr_wr && idx >= 9 && idx <= 16) begin
      slave_bit = tr_rdata[3'(16 - idx)];
    end else begin
      slave_bit = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input logic w, input logic [7:0] sd, input logic aa, input logic da,
                           input logic pa, input logic pd);
    tr_wr = w; tr_rdata = sd; a_ackbit = aa; d_ackbit = da; p_addr = pa; p_data = pd;
    rise_base = rises;
  endtask

  // Full transaction against the model: expected bits on each SCL rise, drive state, timing, rdata
  task automatic run_txn(input string tag, input logic [6:0] a, input logic w, input logic [7:0] d,
                         input logic [7:0] sd, input logic aa, input logic da,
                         input logic pa, input logic pd);
    logic        exp_b[$];
    logic        exp_e[$];
    logic [31:0] ev, oe, ov, oen;
    logic [7:0]  abyte, rd0;
    logic        acked;
    int          bbase, st0, sp0, dn0, n, exp_cyc;

    abyte = {a, ~w};
    acked = (aa == 1'b0) || pa;
    for (int i = 7; i >= 0; i--) begin exp_b.push_back(abyte[i]); exp_e.push_back(1'b1); end
    exp_b.push_back(aa); exp_e.push_back(1'b0);
    if (acked && w) begin
      for (int i = 7; i >= 0; i--) begin exp_b.push_back(d[i]); exp_e.push_back(1'b1); end
      exp_b.push_back(da); exp_e.push_back(1'b0);
    end else if (acked) begin
      for (int i = 7; i >= 0; i--) begin exp_b.push_back(sd[i]); exp_e.push_back(1'b0); end
      exp_b.push_back(1'b1); exp_e.push_back(1'b1);
    end
    exp_b.push_back(1'b0); exp_e.push_back(1'b1);
    exp_cyc = (acked ? 20 : 11) * BITCLK + 1;

    set_slave(w, sd, aa, da, pa, pd);
    bbase = mon_bits.size(); st0 = starts; sp0 = stops; dn0 = dones; rd0 = rdata;

    @(negedge clk);
    addr = a; wr = w; wdata = d; newd = 1'b1;
    @(posedge clk); #1;
    newd = 1'b0; addr = 7'($urandom); wr = 1'($urandom); wdata = 8'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(posedge clk); n++; #1;
      newd = (n == 100);
    end
    newd = 1'b0;
    chk({tag, " cycles"}, n, exp_cyc);
    @(posedge clk); #1;
    chk({tag, " done_one_clk"}, 32'(done), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk({tag, " done_count"}, dones - dn0, 1);
    chk({tag, " rises"}, mon_bits.size() - bbase, exp_b.size());

    ev = '0; oe = '0; ov = '0; oen = '0;
    for (int i = 0; i < exp_b.size(); i++) begin
      ev[i] = exp_b[i]; oe[i] = exp_e[i];
      if (bbase + i < mon_bits.size()) begin
        ov[i] = mon_bits[bbase + i]; oen[i] = mon_en[bbase + i];
      end
    end
    chk({tag, " sda_bits"}, ov, ev);
    chk({tag, " sda_en_bits"}, oen, oe);
    chk({tag, " rdata"}, 32'(rdata), 32'((acked && !w) ? sd : rd0));
    chk({tag, " starts"}, starts - st0, 1);
    chk({tag, " stops"}, stops - sp0, 1);
    chk({tag, " idle_bus"}, {29'd0, scl, sda, dut.sda_en}, 32'b111);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, n;
    rst = 1'b1; newd = 1'b0; wr = 1'b0; addr = 7'd0; wdata = 8'd0;

    repeat (3) @(posedge clk); #1;
    chk("reset_scl", 32'(scl), 32'd1);
    chk("reset_sda_en", 32'(dut.sda_en), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'h00);
    @(negedge clk); rst = 1'b0;
    r0 = rises;
    repeat (100) @(posedge clk); #1;
    chk("idle_no_scl", rises - r0, 0);
    chk("idle_pins", {30'd0, scl, sda}, 32'b11);

    run_txn("wr_a5", 7'h50, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("rd_3c", 7'h50, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("wr_nack", 7'h50, 1'b1, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn("wr_ackpin", 7'h2B, 1'b1, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    run_txn("rd_nack", 7'h11, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_txn($sformatf("rand%0d", k), 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Abort halfway through the data byte of a write
    set_slave(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); addr = 7'h50; wr = 1'b1; wdata = 8'h5A; newd = 1'b1;
    @(negedge clk); newd = 1'b0;
    n = 0;
    while ((rises - rise_base) < 13 && n < 2000) begin @(posedge clk); n++; end
    chk("abort_reached_data", 32'(((rises - rise_base) >= 13) ? 1 : 0), 32'd1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_pins", {28'd0, scl, sda, dut.sda_en, done}, 32'b1110);
    chk("abort_rdata", 32'(rdata), 32'h00);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    r0 = rises;
    repeat (100) @(posedge clk); #1;
    chk("abort_idle_no_scl", rises - r0, 0);

    run_txn("after_abort", 7'h3A, 1'b1, 8'h96, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("after_abort_rd", 7'h3A, 1'b0, 8'h00, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
